// File: rtl/randomizer_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// randomizer_pkg
// Shared definitions for the frame randomizer controller: LFSR length,
// default frame length and the controller state encoding.
// -----------------------------------------------------------------------------
package randomizer_pkg;

    localparam int unsigned RND_LFSR_W    = 15;
    localparam int unsigned RND_FRAME_LEN = 96;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } rnd_state_t;

endpackage

// File: rtl/randomizer_frame_ctrl_out_stage.sv
// -----------------------------------------------------------------------------
// rnd_out_stage
// Single-entry output register for the scrambled bit stream. Holds the
// accepted payload bit, its valid flag and the last-bit marker.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_load         payload bit accepted this cycle
//   i_bit          payload bit to capture
//   i_last         captured bit is the final bit of the frame
//   i_pop          sink accepts the held bit
//   o_hold         held payload bit
//   o_valid        held bit is valid
//   o_last         held bit is the final bit of the frame
// -----------------------------------------------------------------------------
module rnd_out_stage (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_bit,
    input  logic i_last,
    input  logic i_pop,
    output logic o_hold,
    output logic o_valid,
    output logic o_last
);

    logic r_hold;
    logic r_valid;
    logic r_last;

    // A load wins over a pop so a same-cycle accept refills without a bubble.
    // r_hold is left untouched on pop so the bit stays stable between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_hold  <= i_bit;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (i_pop) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_hold  = r_hold;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/randomizer_frame_ctrl.sv
// -----------------------------------------------------------------------------
// randomizer_frame_ctrl
// Sequences an external 15-bit LFSR randomizer one frame at a time: loads the
// frame seed serially (MSB first), then streams FRAME_LEN payload bits through
// a single-stage valid/ready pipe, XORing each with the registered PRBS bit.
// Optional feature macro: RANDOMIZER_BYPASS_EN (adds 'bypass' input; a bypass
// frame skips seeding, never enables the LFSR and passes payload unscrambled).
// Ports:
//   clk, async_reset          clock, asynchronous active-high reset
//   start, seed               frame start request and seed (sampled in IDLE)
//   bypass                    (RANDOMIZER_BYPASS_EN only) unscrambled frame
//   in_valid, in_bit, in_ready     payload input handshake
//   out_valid, out_bit, out_last, out_ready   scrambled output handshake
//   busy                      controller not idle
//   frame_done                pulse when the final bit is taken by the sink
//   lfsr_enable, lfsr_load, lfsr_data_in, lfsr_data_out   LFSR control/data
// -----------------------------------------------------------------------------
module randomizer_frame_ctrl
    import randomizer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = RND_FRAME_LEN,
    parameter int unsigned LFSR_W    = RND_LFSR_W,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
`ifdef RANDOMIZER_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_bit,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              lfsr_enable,
    output logic              lfsr_load,
    output logic              lfsr_data_in,
    input  logic              lfsr_data_out
);

    localparam int unsigned SCNT_W = (LFSR_W > 2) ? $clog2(LFSR_W) : 1;

    rnd_state_t        r_state;
    rnd_state_t        w_state_nxt;
    logic [LFSR_W-1:0] r_seed;
    logic [SCNT_W-1:0] r_seed_cnt;
    logic [CNT_W-1:0]  r_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_done;
    logic w_lfsr_en;
    logic w_lfsr_load;
    logic w_lfsr_din;
    logic w_seed_last;
    logic w_bit_last;
    logic w_hold;
    logic w_out_valid;
    logic w_out_last;
    logic w_start_bypass;
    logic w_bypass;

`ifdef RANDOMIZER_BYPASS_EN
    logic r_bypass;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_bypass <= bypass;
        end
    end

    assign w_start_bypass = bypass;
    assign w_bypass       = r_bypass;
`else
    assign w_start_bypass = 1'b0;
    assign w_bypass       = 1'b0;
`endif

    assign w_seed_last = (r_seed_cnt == SCNT_W'(LFSR_W - 1));
    assign w_bit_last  = (r_cnt == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_lfsr_en   = 1'b0;
        w_lfsr_load = 1'b0;
        w_lfsr_din  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_start_bypass ? ST_RUN : ST_SEED;
                end
            end
            ST_SEED: begin
                w_lfsr_en   = 1'b1;
                w_lfsr_load = 1'b1;
                w_lfsr_din  = r_seed[LFSR_W-1];
                if (w_seed_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = !w_out_valid || out_ready;
                w_accept   = in_valid && w_in_ready;
                if (w_accept) begin
                    // PRBS advances only on accept so out_bit is frozen while stalled.
                    w_lfsr_en = !w_bypass;
                    if (w_bit_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_out_valid && out_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The seed register shifts left during SEED, so its MSB is always the
    // next serial load bit (seed[LFSR_W-1-k] on SEED cycle k).
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state    <= ST_IDLE;
            r_seed     <= '0;
            r_seed_cnt <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_seed <= seed;
                    end
                end
                ST_SEED: begin
                    r_seed     <= {r_seed[LFSR_W-2:0], 1'b0};
                    r_seed_cnt <= w_seed_last ? '0 : r_seed_cnt + 1'b1;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    rnd_out_stage u_out_stage (
        .clk     (clk),
        .rst     (async_reset),
        .i_load  (w_accept),
        .i_bit   (in_bit),
        .i_last  (w_bit_last),
        .i_pop   (out_ready),
        .o_hold  (w_hold),
        .o_valid (w_out_valid),
        .o_last  (w_out_last)
    );

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_last     = w_out_last;
    assign out_bit      = w_hold ^ (lfsr_data_out & ~w_bypass);
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = w_done;
    assign lfsr_enable  = w_lfsr_en;
    assign lfsr_load    = w_lfsr_load;
    assign lfsr_data_in = w_lfsr_din;

endmodule

// File: tb/tb_randomizer_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_randomizer_frame_ctrl
// Bench for randomizer_frame_ctrl together with a 15-bit x^15+x^14+1 LFSR.
// -----------------------------------------------------------------------------
module tb_randomizer_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [14:0] seed;
`ifdef RANDOMIZER_BYPASS_EN
    logic        bypass;
`endif
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic        out_bit;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    logic        lfsr_enable;
    logic        lfsr_load;
    logic        lfsr_data_in;
    logic        lfsr_dout;

    int errors = 0;
    int checks = 0;

    localparam logic [14:0] SEED_A = 15'b100101010000000;

    randomizer_frame_ctrl #(.FRAME_LEN(96), .LFSR_W(15)) dut (
        .clk           (clk),
        .async_reset   (rst),
        .start         (start),
        .seed          (seed),
`ifdef RANDOMIZER_BYPASS_EN
        .bypass        (bypass),
`endif
        .in_valid      (in_valid),
        .in_bit        (in_bit),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_bit       (out_bit),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .lfsr_enable   (lfsr_enable),
        .lfsr_load     (lfsr_load),
        .lfsr_data_in  (lfsr_data_in),
        .lfsr_data_out (lfsr_dout)
    );

    // Randomizer LFSR: serial load shifts toward bit 15; run mode uses
    // taps 15 and 14 and registers the feedback bit as the PRBS output.
    logic [15:1] lfsr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q    <= '0;
            lfsr_dout <= 1'b0;
        end else if (lfsr_enable) begin
            if (lfsr_load) begin
                lfsr_q <= {lfsr_q[14:1], lfsr_data_in};
            end else begin
                lfsr_q    <= {lfsr_q[14:1], lfsr_q[15] ^ lfsr_q[14]};
                lfsr_dout <= lfsr_q[15] ^ lfsr_q[14];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  in_ready,     0);
        check({tag, "_out_valid"}, out_valid,    0);
        check({tag, "_out_bit"},   out_bit,      0);
        check({tag, "_out_last"},  out_last,     0);
        check({tag, "_busy"},      busy,         0);
        check({tag, "_done"},      frame_done,   0);
        check({tag, "_lfsr_en"},   lfsr_enable,  0);
        check({tag, "_lfsr_ld"},   lfsr_load,    0);
        check({tag, "_lfsr_din"},  lfsr_data_in, 0);
    endtask

    // Software PRBS model: bit i is the i-th feedback bit after seeding.
    function automatic logic [95:0] prbs_seq(input logic [14:0] sd);
        logic [14:0] s;
        logic [95:0] r;
        logic        fb;
        s = sd;
        r = '0;
        for (int i = 0; i < 96; i++) begin
            fb   = s[14] ^ s[13];
            r[i] = fb;
            s    = {s[13:0], fb};
        end
        return r;
    endfunction

    // Payload patterns: 0 = zeros, 1 = 0xFF, 2 = 0xA5 bytes MSB first.
    function automatic logic pay_bit(input int mode, input int i);
        logic [7:0] a5;
        a5 = 8'hA5;
        case (mode)
            1:       return 1'b1;
            2:       return a5[7 - (i % 8)];
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic st;
        logic iv;
        logic ib;
        logic ordy;
        logic e_busy;
        logic e_rdy;
        logic e_ov;
        logic e_en;
        logic e_ld;
        logic e_din;
        logic e_obit;
    } vec_t;

    function automatic vec_t mk(input logic st, iv, ib, ordy, e_busy, e_rdy, e_ov,
                                input logic e_en, e_ld, e_din, e_obit);
        vec_t v;
        v.st = st; v.iv = iv; v.ib = ib; v.ordy = ordy;
        v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_ov = e_ov;
        v.e_en = e_en; v.e_ld = e_ld; v.e_din = e_din; v.e_obit = e_obit;
        return v;
    endfunction

    task automatic run_frame(input logic [14:0] sd, input int pmode, input int smode,
                             input logic byp, input int abort_at, input logic poke);
        logic [95:0] pr;
        logic [95:0] expv;
        int   src_i, dst_i, zero_cnt, done_cnt;
        logic run_seen, stalled, stall_bit, en_seen, poked, finished, aborted, last_seen;
        pr = prbs_seq(sd);
        for (int i = 0; i < 96; i++) expv[i] = pay_bit(pmode, i) ^ (byp ? 1'b0 : pr[i]);
        src_i = 0; dst_i = 0; zero_cnt = 0; done_cnt = 0;
        run_seen = 0; stalled = 0; stall_bit = 0; en_seen = 0;
        poked = 0; finished = 0; aborted = 0; last_seen = 0;

        @(negedge clk);
        start = 1'b1; seed = sd; in_valid = 1'b0; out_ready = 1'b1;
`ifdef RANDOMIZER_BYPASS_EN
        bypass = byp;
`endif
        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            @(negedge clk);
            start     = poke && ((cyc == 3) || (dst_i == 30 && !poked));
            if (start && dst_i == 30) poked = 1'b1;
            in_valid  = (src_i < 96);
            in_bit    = (src_i < 96) ? pay_bit(pmode, src_i) : 1'b0;
            out_ready = (smode == 1) ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (abort_at >= 0 && dst_i == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                finished = 1'b1;
            end else if (last_seen) begin
                check("idle_after_done_busy", busy, 0);
                check("idle_after_done_ov", out_valid, 0);
                finished = 1'b1;
            end else begin
                en_seen |= lfsr_enable;
                if (!run_seen) begin
                    if (in_ready) begin
                        run_seen = 1'b1;
                        check("seed_cycles", zero_cnt, byp ? 0 : 15);
                    end else begin
                        zero_cnt++;
                    end
                end
                if (stalled) check("stall_hold", out_bit, stall_bit);
                if (frame_done) done_cnt++;
                if (out_valid && out_ready) begin
                    if (dst_i < 96) begin
                        check($sformatf("out_bit[%0d]", dst_i), out_bit, expv[dst_i]);
                        check($sformatf("out_last[%0d]", dst_i), out_last, dst_i == 95);
                        check($sformatf("frame_done[%0d]", dst_i), frame_done, dst_i == 95);
                    end else begin
                        check("xfer_overrun", dst_i + 1, 96);
                    end
                    dst_i++;
                    if (dst_i == 96) last_seen = 1'b1;
                end
                stalled   = out_valid && !out_ready;
                stall_bit = out_bit;
                if (in_valid && in_ready) src_i++;
            end
        end
        start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        if (!aborted) begin
            check("xfer_count", dst_i, 96);
            check("src_count", src_i, 96);
            check("done_pulses", done_cnt, 1);
            if (byp) check("bypass_lfsr_en", en_seen, 0);
        end
    endtask

    vec_t tbl[24];

    initial begin
        logic [14:0] sb;
        sb = SEED_A;

        // Control-path table for one frame start with seed A.
        tbl[0]  = mk(0,0,0,1, 0,0,0,0,0,0,0);
        tbl[1]  = mk(1,0,0,1, 0,0,0,0,0,0,0);
        for (int k = 0; k < 15; k++)
            tbl[2 + k] = mk(k == 2, 1, 1, 1, 1, 0, 0, 1, 1, sb[14 - k], 0);
        tbl[17] = mk(0,0,0,1, 1,1,0,0,0,0,0);
        tbl[18] = mk(0,1,0,1, 1,1,0,1,0,0,0);
        tbl[19] = mk(0,0,0,0, 1,0,1,0,0,0,1);
        tbl[20] = mk(0,1,0,0, 1,0,1,0,0,0,1);
        tbl[21] = mk(0,1,1,1, 1,1,1,1,0,0,1);
        tbl[22] = mk(0,0,0,1, 1,1,1,0,0,0,1);
        tbl[23] = mk(0,0,0,1, 1,1,0,0,0,0,0);

        rst = 1'b1; start = 1'b0; seed = SEED_A; in_valid = 1'b0;
        in_bit = 1'b0; out_ready = 1'b1;
`ifdef RANDOMIZER_BYPASS_EN
        bypass = 1'b0;
`endif
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 24; r++) begin
            @(negedge clk);
            start = tbl[r].st; in_valid = tbl[r].iv; in_bit = tbl[r].ib;
            out_ready = tbl[r].ordy;
            #1;
            check($sformatf("tbl%0d_busy", r),  busy,        tbl[r].e_busy);
            check($sformatf("tbl%0d_rdy", r),   in_ready,    tbl[r].e_rdy);
            check($sformatf("tbl%0d_ov", r),    out_valid,   tbl[r].e_ov);
            check($sformatf("tbl%0d_en", r),    lfsr_enable, tbl[r].e_en);
            check($sformatf("tbl%0d_ld", r),    lfsr_load,   tbl[r].e_ld);
            if (tbl[r].e_ld) check($sformatf("tbl%0d_din", r), lfsr_data_in, tbl[r].e_din);
            if (tbl[r].e_ov) check($sformatf("tbl%0d_obit", r), out_bit, tbl[r].e_obit);
        end

        // Abort the partially streamed frame.
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("tbl_abort");
        @(negedge clk);
        rst = 1'b0;

        run_frame(SEED_A, 0, 0, 1'b0, -1, 1'b0);   // zeros: raw PRBS
        run_frame(SEED_A, 1, 0, 1'b0, -1, 1'b0);   // ones: inverted PRBS
        run_frame(SEED_A, 2, 1, 1'b0, -1, 1'b0);   // toggling out_ready
        run_frame(SEED_A, 0, 0, 1'b0, -1, 1'b1);   // stray start pulses
        run_frame(15'h0001, 0, 0, 1'b0, -1, 1'b0);
        run_frame(SEED_A, 0, 0, 1'b0, 40, 1'b0);   // reset at bit 40
        run_frame(SEED_A, 0, 0, 1'b0, -1, 1'b0);
`ifdef RANDOMIZER_BYPASS_EN
        run_frame(SEED_A, 2, 0, 1'b1, -1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
